// File: rtl/booth_pkg.sv
// Shared types for the sequential Booth multiplier: FSM states and the
// decoded action for each {acc[0], booth} bit pair.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        NOP = 2'd0,
        ADD = 2'd1,
        SUB = 2'd2
    } booth_op_t;

    function automatic booth_op_t booth_decode(input logic [1:0] pair);
        case (pair)
            2'b01:   return ADD;
            2'b10:   return SUB;
            default: return NOP;
        endcase
    endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of the multiplicand into
// the upper half of the accumulator, followed by an arithmetic right shift.
module booth_step
    import booth_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH+1:0] acc_i,
    input  logic               booth_i,
    input  logic [WIDTH:0]     mcand_i,
    output logic [2*WIDTH+1:0] acc_o,
    output logic               booth_o
);

    logic [WIDTH:0]     upper;
    logic [2*WIDTH+1:0] acc_new;

    always_comb begin
        upper = acc_i[2*WIDTH+1:WIDTH+1];
        case (booth_decode({acc_i[0], booth_i}))
            ADD:     upper = upper + mcand_i;
            SUB:     upper = upper - mcand_i;
            default: upper = acc_i[2*WIDTH+1:WIDTH+1];
        endcase
        acc_new = {upper, acc_i[WIDTH:0]};
        acc_o   = {acc_new[2*WIDTH+1], acc_new[2*WIDTH+1:1]};
        booth_o = acc_new[0];
    end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier with signed/unsigned mode, start/ready
// input handshake, valid/ready result handshake and synchronous abort.
module booth_mul_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 2)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    input  logic                 abort,
    output logic                 ready,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     product_hi,
    output logic [WIDTH-1:0]     product_lo
);

    localparam int ACC_W = 2*WIDTH + 2;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic                booth_q, booth_d;
    logic [WIDTH:0]      mcand_q, mcand_d;
    logic [2*WIDTH-1:0]  product_q, product_d;

    logic [ACC_W-1:0]    step_acc;
    logic                step_booth;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .acc_i   (acc_q),
        .booth_i (booth_q),
        .mcand_i (mcand_q),
        .acc_o   (step_acc),
        .booth_o (step_booth)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        booth_d   = booth_q;
        mcand_d   = mcand_q;
        product_d = product_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    // One extra sign/zero bit lets unsigned MSB=1 and signed MIN operands stay exact.
                    mcand_d = {is_signed & op_a[WIDTH-1], op_a};
                    acc_d   = {{(WIDTH+1){1'b0}}, is_signed & op_b[WIDTH-1], op_b};
                    booth_d = 1'b0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                acc_d   = step_acc;
                booth_d = step_booth;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d   = DONE;
                    product_d = step_acc[2*WIDTH-1:0];
                    cnt_d     = '0;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            booth_q   <= 1'b0;
            mcand_q   <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            booth_q   <= booth_d;
            mcand_q   <= mcand_d;
            product_q <= product_d;
        end
    end

    assign ready      = (state_q == IDLE);
    assign busy       = (state_q == RUN);
    assign out_valid  = (state_q == DONE);
    assign product    = product_q;
    assign product_hi = product_q[2*WIDTH-1:WIDTH];
    assign product_lo = product_q[WIDTH-1:0];

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed and randomised checks of booth_mul_seq at WIDTH=32 and WIDTH=8
// using expected-result queues filled at accept time.
module tb_booth_mul_seq;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    logic        s32_start = 1'b0, s32_signed = 1'b0, s32_abort = 1'b0, s32_oready = 1'b1;
    logic [31:0] s32_a = '0, s32_b = '0;
    logic        r32, b32, v32;
    logic [63:0] p32;
    logic [31:0] ph32, pl32;

    logic        s8_start = 1'b0, s8_signed = 1'b0, s8_abort = 1'b0, s8_oready = 1'b1;
    logic [7:0]  s8_a = '0, s8_b = '0;
    logic        r8, b8, v8;
    logic [15:0] p8;
    logic [7:0]  ph8, pl8;

    booth_mul_seq #(.WIDTH(32)) u32 (
        .CLK(CLK), .RST(RST), .start(s32_start), .is_signed(s32_signed),
        .op_a(s32_a), .op_b(s32_b), .abort(s32_abort),
        .ready(r32), .busy(b32), .out_valid(v32), .out_ready(s32_oready),
        .product(p32), .product_hi(ph32), .product_lo(pl32)
    );

    booth_mul_seq #(.WIDTH(8)) u8 (
        .CLK(CLK), .RST(RST), .start(s8_start), .is_signed(s8_signed),
        .op_a(s8_a), .op_b(s8_b), .abort(s8_abort),
        .ready(r8), .busy(b8), .out_valid(v8), .out_ready(s8_oready),
        .product(p8), .product_hi(ph8), .product_lo(pl8)
    );

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;
    logic [63:0] sb32[$];
    logic [15:0] sb8[$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref8(input logic s, input logic [7:0] a, input logic [7:0] b);
        logic [31:0] ea, eb, pr;
        ea = s ? {{24{a[7]}}, a} : {24'b0, a};
        eb = s ? {{24{b[7]}}, b} : {24'b0, b};
        pr = ea * eb;
        return pr[15:0];
    endfunction

    task automatic start32(input logic s, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp);
        int unsigned n = 0;
        while (!r32 && n < 200) begin
            @(posedge CLK); @(negedge CLK); n++;
        end
        check("ready_wait32", r32, 1);
        s32_start = 1'b1; s32_signed = s; s32_a = a; s32_b = b;
        @(posedge CLK);
        sb32.push_back(exp);
        @(negedge CLK);
        s32_start = 1'b0; s32_a = $urandom; s32_b = $urandom; s32_signed = $urandom_range(0, 1);
    endtask

    task automatic finish32(input string tag, output int unsigned lat);
        logic [63:0] exp;
        lat = 0;
        while (!v32 && lat < 100) begin
            @(posedge CLK); lat++; @(negedge CLK);
        end
        check({tag, "_valid"}, v32, 1);
        if (sb32.size() != 0) exp = sb32.pop_front();
        else exp = 'x;
        check({tag, "_product"}, p32, exp);
        check({tag, "_hi"}, ph32, exp[63:32]);
        check({tag, "_lo"}, pl32, exp[31:0]);
    endtask

    task automatic run8(input logic s, input logic [7:0] a, input logic [7:0] b);
        int unsigned n = 0;
        logic [15:0] exp;
        while (!r8 && n < 50) begin
            @(posedge CLK); @(negedge CLK); n++;
        end
        check("ready_wait8", r8, 1);
        s8_start = 1'b1; s8_signed = s; s8_a = a; s8_b = b;
        @(posedge CLK);
        sb8.push_back(ref8(s, a, b));
        @(negedge CLK);
        s8_start = 1'b0; s8_a = $urandom; s8_b = $urandom;
        n = 0;
        while (!v8 && n < 50) begin
            @(posedge CLK); n++; @(negedge CLK);
        end
        check("sweep8_valid", v8, 1);
        if (sb8.size() != 0) exp = sb8.pop_front();
        else exp = 'x;
        check("sweep8_product", p8, exp);
        check("sweep8_lo", pl8, exp[7:0]);
        @(posedge CLK); @(negedge CLK);
    endtask

    initial begin
        int unsigned lat;
        logic        seen;
        logic [63:0] held;
        logic [7:0]  a8, b8v;
        logic        s8;

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_ready32", r32, 1);
        check("rst_busy32", b32, 0);
        check("rst_valid32", v32, 0);
        check("rst_product32", p32, 0);
        RST = 1'b0;

        // Signed -3 * 7 and first-result latency
        start32(1'b1, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB);
        finish32("t1", lat);
        check("t1_latency_edges", lat, 33);
        @(posedge CLK); @(negedge CLK);
        check("t1_ready_after", r32, 1);
        check("t1_valid_after", v32, 0);
        check("t1_product_kept", p32, 64'hFFFF_FFFF_FFFF_FFEB);

        start32(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        finish32("t2u", lat);
        @(posedge CLK); @(negedge CLK);
        start32(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
        finish32("t2s", lat);
        @(posedge CLK); @(negedge CLK);

        start32(1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        finish32("t3s", lat);
        @(posedge CLK); @(negedge CLK);
        start32(1'b0, 32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000);
        finish32("t3u", lat);
        @(posedge CLK); @(negedge CLK);

        // Result held while the consumer stalls; start ignored meanwhile
        s32_oready = 1'b0;
        held = 64'hFFFF_FFED_CBA9_8800;
        start32(1'b1, 32'h1234_5678, 32'hFFFF_FF00, held);
        finish32("t4", lat);
        for (int i = 0; i < 10; i++) begin
            s32_start = (i == 3);
            @(posedge CLK); @(negedge CLK);
            check("t4_valid_hold", v32, 1);
            check("t4_product_hold", p32, held);
            check("t4_ready_low", r32, 0);
        end
        s32_start = 1'b0;
        s32_oready = 1'b1;
        @(posedge CLK); @(negedge CLK);
        check("t4_ready_release", r32, 1);
        check("t4_valid_release", v32, 0);
        check("t4_busy_release", b32, 0);

        // Abort mid-run beats a simultaneous start
        start32(1'b0, 32'hDEAD_BEEF, 32'h0000_1234, 64'h0);
        void'(sb32.pop_back());
        repeat (15) @(posedge CLK);
        @(negedge CLK);
        check("t5_busy_before", b32, 1);
        s32_abort = 1'b1; s32_start = 1'b1; s32_a = 32'd7; s32_b = 32'd9;
        @(posedge CLK); @(negedge CLK);
        s32_abort = 1'b0; s32_start = 1'b0;
        check("t5_ready", r32, 1);
        check("t5_busy", b32, 0);
        check("t5_valid", v32, 0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge CLK); @(negedge CLK);
            seen = seen | v32;
        end
        check("t5_no_valid", seen, 0);
        start32(1'b0, 32'd5, 32'd6, 64'd30);
        finish32("t5_next", lat);
        @(posedge CLK); @(negedge CLK);

        // Reset during RUN clears outputs
        start32(1'b1, 32'h1111_1111, 32'd3, 64'h0);
        void'(sb32.pop_back());
        repeat (10) @(posedge CLK);
        @(negedge CLK);
        check("t6_busy_before", b32, 1);
        RST = 1'b1;
        @(posedge CLK); @(negedge CLK);
        check("t6_ready", r32, 1);
        check("t6_busy", b32, 0);
        check("t6_valid", v32, 0);
        check("t6_product", p32, 0);
        RST = 1'b0;
        @(posedge CLK); @(negedge CLK);
        check("t6_idle_after", r32, 1);

        for (int i = 0; i < 2000; i++) begin
            case (i)
                0: begin s8 = 1'b1; a8 = 8'h80; b8v = 8'h80; end
                1: begin s8 = 1'b0; a8 = 8'hFF; b8v = 8'hFF; end
                2: begin s8 = 1'b1; a8 = 8'hFF; b8v = 8'hFF; end
                3: begin s8 = 1'b1; a8 = 8'h80; b8v = 8'h7F; end
                4: begin s8 = 1'b0; a8 = 8'h80; b8v = 8'hFF; end
                5: begin s8 = 1'b1; a8 = 8'h00; b8v = 8'h80; end
                default: begin
                    s8 = 1'($urandom_range(0, 1));
                    a8 = 8'($urandom);
                    b8v = 8'($urandom);
                end
            endcase
            run8(s8, a8, b8v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
